// File: rtl/sdram_slot_sched_if.sv
// Bundle of loader, NES and SDRAM-side signals around the slot scheduler.
// The scheduler takes the slave side; whoever drives the loader/NES strobes takes master.
interface sdram_slot_sched_if #(
    parameter int ADDR_W    = 22,
    parameter int SD_ADDR_W = 25
);
    logic                 downloading;
    logic                 reset_req;
    logic                 loader_write;
    logic [ADDR_W-1:0]    loader_addr;
    logic [7:0]           loader_data;
    logic [ADDR_W-1:0]    nes_addr;
    logic                 nes_read_cpu;
    logic                 nes_read_ppu;
    logic                 nes_write;
    logic [7:0]           nes_dout;
    logic                 nes_ce;
    logic                 reset_nes;
    logic                 clkref;
    logic [1:0]           phase;
    logic [SD_ADDR_W-1:0] sd_addr;
    logic [7:0]           sd_din;
    logic                 sd_we;
    logic                 sd_oeA;
    logic                 sd_oeB;
    logic                 loader_busy;
    logic                 fifo_ovf;

    modport master (
        output downloading, reset_req, loader_write, loader_addr, loader_data,
               nes_addr, nes_read_cpu, nes_read_ppu, nes_write, nes_dout,
        input  nes_ce, reset_nes, clkref, phase, sd_addr, sd_din, sd_we,
               sd_oeA, sd_oeB, loader_busy, fifo_ovf
    );

    modport slave (
        input  downloading, reset_req, loader_write, loader_addr, loader_data,
               nes_addr, nes_read_cpu, nes_read_ppu, nes_write, nes_dout,
        output nes_ce, reset_nes, clkref, phase, sd_addr, sd_din, sd_we,
               sd_oeA, sd_oeB, loader_busy, fifo_ovf
    );
endinterface

// File: rtl/sdram_slot_sched.sv
// 4-phase slot scheduler for the shared NES SDRAM port: phase/clkref generation,
// NES reset hold, 2-entry loader write FIFO issued one write per slot, and SDRAM mux.
module sdram_slot_sched #(
    parameter int ADDR_W    = 22,
    parameter int SD_ADDR_W = 25
) (
    input  logic                clk,
    input  logic                reset,
    sdram_slot_sched_if.slave   bus
);
    localparam int DEPTH = 2;

    logic [1:0]        r_phase;
    logic              r_init_hold;
    logic              r_dl_d;
    logic              r_fifo_ovf;
    logic [1:0]        r_count;
    logic              r_rd_ptr;
    logic              r_wr_ptr;
    logic [ADDR_W-1:0] r_fifo_addr [DEPTH];
    logic [7:0]        r_fifo_data [DEPTH];
    logic              r_wr_active;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [7:0]        r_wr_data;

    logic w_slot_end;
    logic w_fifo_empty;
    logic w_fifo_full;
    logic w_fifo_rd;
    logic w_fifo_wr;
    logic w_bypass;
    logic w_drop;
    logic w_dl_rise;
    logic w_loader_busy;
    logic w_reset_nes;

    assign w_slot_end   = (r_phase == 2'd3);
    assign w_fifo_empty = (r_count == 2'd0);
    assign w_fifo_full  = (r_count == 2'(DEPTH));
    assign w_fifo_rd    = w_slot_end && !w_fifo_empty;
    // An empty FIFO at slot end hands the incoming strobe straight to the window.
    assign w_bypass     = w_slot_end && w_fifo_empty && bus.loader_write;
    assign w_fifo_wr    = bus.loader_write && !w_bypass && (!w_fifo_full || w_fifo_rd);
    assign w_drop       = bus.loader_write && w_fifo_full && !w_fifo_rd;
    assign w_dl_rise    = bus.downloading && !r_dl_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_phase     <= 2'd0;
            r_init_hold <= 1'b1;
            r_dl_d      <= 1'b0;
            r_fifo_ovf  <= 1'b0;
        end else begin
            r_phase <= r_phase + 2'd1;
            r_dl_d  <= bus.downloading;
            if (bus.downloading)
                r_init_hold <= 1'b0;
            if (w_drop)
                r_fifo_ovf <= 1'b1;
            else if (w_dl_rise)
                r_fifo_ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count  <= 2'd0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
        end else begin
            if (w_fifo_wr)
                r_wr_ptr <= ~r_wr_ptr;
            if (w_fifo_rd)
                r_rd_ptr <= ~r_rd_ptr;
            case ({w_fifo_wr, w_fifo_rd})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_fifo
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_fifo_addr[gi] <= '0;
                    r_fifo_data[gi] <= '0;
                end else if (w_fifo_wr && (r_wr_ptr == 1'(gi))) begin
                    r_fifo_addr[gi] <= bus.loader_addr;
                    r_fifo_data[gi] <= bus.loader_data;
                end
            end
        end
    endgenerate

    // The window for the coming slot (phases 0..3) is latched at phase 3 only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_active <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
        end else if (w_slot_end) begin
            r_wr_active <= w_fifo_rd || w_bypass;
            if (w_fifo_rd) begin
                r_wr_addr <= r_fifo_addr[r_rd_ptr];
                r_wr_data <= r_fifo_data[r_rd_ptr];
            end else if (w_bypass) begin
                r_wr_addr <= bus.loader_addr;
                r_wr_data <= bus.loader_data;
            end
        end
    end

    assign w_loader_busy = bus.downloading || !w_fifo_empty || r_wr_active;
    assign w_reset_nes   = r_init_hold || bus.reset_req || w_loader_busy;

    assign bus.phase       = r_phase;
    assign bus.clkref      = r_phase[1];
    assign bus.nes_ce      = w_slot_end && !w_reset_nes;
    assign bus.reset_nes   = w_reset_nes;
    assign bus.loader_busy = w_loader_busy;
    assign bus.fifo_ovf    = r_fifo_ovf;

    always_comb begin
        bus.sd_addr = {{(SD_ADDR_W-ADDR_W){1'b0}}, bus.nes_addr};
        bus.sd_din  = bus.nes_dout;
        bus.sd_we   = bus.nes_write;
        bus.sd_oeA  = bus.nes_read_cpu;
        bus.sd_oeB  = bus.nes_read_ppu;
        if (w_loader_busy) begin
            bus.sd_addr = {{(SD_ADDR_W-ADDR_W){1'b0}}, r_wr_addr};
            bus.sd_din  = r_wr_data;
            bus.sd_we   = r_wr_active;
            bus.sd_oeA  = 1'b0;
            bus.sd_oeB  = 1'b0;
        end
    end
endmodule

// File: tb/tb_sdram_slot_sched.sv
// Randomized and directed bench for sdram_slot_sched against a queue-based slot model.
module tb_sdram_slot_sched;
    localparam int ADDR_W    = 22;
    localparam int SD_ADDR_W = 25;

    logic clk;
    logic reset;

    sdram_slot_sched_if #(.ADDR_W(ADDR_W), .SD_ADDR_W(SD_ADDR_W)) bus ();

    sdram_slot_sched #(.ADDR_W(ADDR_W), .SD_ADDR_W(SD_ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [7:0]        d;
    } ent_t;

    int   n_checks;
    int   n_fail;
    int   m_phase;
    bit   m_init;
    bit   m_ovf;
    bit   m_prev_dl;
    bit   m_wact;
    ent_t m_win;
    ent_t m_q[$];
    bit   dl;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_phase   = 0;
        m_init    = 1'b1;
        m_ovf     = 1'b0;
        m_prev_dl = 1'b0;
        m_wact    = 1'b0;
        m_win     = '{a: '0, d: '0};
        m_q.delete();
    endtask

    // One rising edge of the slot model, using the inputs presented to the DUT.
    task automatic m_clock();
        ent_t inc;
        inc = '{a: bus.loader_addr, d: bus.loader_data};
        if (bus.downloading) m_init = 1'b0;
        if (bus.downloading && !m_prev_dl) m_ovf = 1'b0;
        m_prev_dl = bus.downloading;
        if (m_phase == 3) begin
            if (m_q.size() > 0) begin
                m_win  = m_q.pop_front();
                m_wact = 1'b1;
                if (bus.loader_write) m_q.push_back(inc);
            end else if (bus.loader_write) begin
                m_win  = inc;
                m_wact = 1'b1;
            end else begin
                m_wact = 1'b0;
            end
        end else if (bus.loader_write) begin
            if (m_q.size() < 2) m_q.push_back(inc);
            else m_ovf = 1'b1;
        end
        m_phase = (m_phase + 1) % 4;
    endtask

    task automatic compare_all();
        bit busy;
        bit rn;
        busy = bus.downloading || (m_q.size() != 0) || m_wact;
        rn   = m_init || bus.reset_req || busy;
        check("phase",       32'(bus.phase),       32'(m_phase));
        check("clkref",      32'(bus.clkref),      32'(m_phase >= 2));
        check("reset_nes",   32'(bus.reset_nes),   32'(rn));
        check("nes_ce",      32'(bus.nes_ce),      32'((m_phase == 3) && !rn));
        check("loader_busy", 32'(bus.loader_busy), 32'(busy));
        check("fifo_ovf",    32'(bus.fifo_ovf),    32'(m_ovf));
        check("sd_we",       32'(bus.sd_we),       busy ? 32'(m_wact) : 32'(bus.nes_write));
        check("sd_addr",     32'(bus.sd_addr),     busy ? 32'(m_win.a) : 32'(bus.nes_addr));
        check("sd_din",      32'(bus.sd_din),      busy ? 32'(m_win.d) : 32'(bus.nes_dout));
        check("sd_oeA",      32'(bus.sd_oeA),      busy ? 32'(0) : 32'(bus.nes_read_cpu));
        check("sd_oeB",      32'(bus.sd_oeB),      busy ? 32'(0) : 32'(bus.nes_read_ppu));
    endtask

    task automatic cycle();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        if (bus.loader_write)
            $display("loader_write addr=%06h data=%02h phase=%0d queued=%0d", bus.loader_addr, bus.loader_data, m_phase, m_q.size());
        if (reset) m_reset();
        else m_clock();
        #1;
    endtask

    task automatic idle_inputs();
        bus.loader_write = 1'b0;
        bus.nes_read_cpu = 1'b0;
        bus.nes_read_ppu = 1'b0;
        bus.nes_write    = 1'b0;
    endtask

    task automatic to_phase(input int p);
        for (int k = 0; k < 4 && m_phase != p; k++) cycle();
    endtask

    task automatic strobe(input logic [ADDR_W-1:0] a, input logic [7:0] d);
        bus.loader_write = 1'b1;
        bus.loader_addr  = a;
        bus.loader_data  = d;
        cycle();
        bus.loader_write = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b1;
        bus.downloading = 1'b0;
        bus.reset_req   = 1'b0;
        bus.loader_addr = '0;
        bus.loader_data = '0;
        bus.nes_addr    = '0;
        bus.nes_dout    = '0;
        idle_inputs();
        m_reset();

        // Reset then idle
        repeat (3) cycle();
        reset = 1'b0;
        repeat (8) cycle();

        // Single aligned write, bypass path
        bus.downloading = 1'b1;
        cycle();
        to_phase(3);
        strobe(22'h012345, 8'hA5);
        check("aligned_we", 32'(bus.sd_we), 32'(1));
        check("aligned_addr", 32'(bus.sd_addr), 32'h0012345);
        repeat (6) cycle();

        // Burst overflow at phases 0,1,2
        to_phase(0);
        strobe(22'h000100, 8'h11);
        strobe(22'h000101, 8'h22);
        strobe(22'h000102, 8'h33);
        check("burst_ovf", 32'(bus.fifo_ovf), 32'(1));
        repeat (12) cycle();

        // Download end with one entry queued
        to_phase(0);
        strobe(22'h03ABCD, 8'h5E);
        bus.downloading = 1'b0;
        repeat (14) cycle();

        // NES passthrough
        bus.nes_read_cpu = 1'b1;
        bus.nes_addr     = 22'h000FFC;
        repeat (2) cycle();
        bus.nes_read_cpu = 1'b0;
        bus.nes_write    = 1'b1;
        bus.nes_dout     = 8'h3C;
        repeat (2) cycle();
        idle_inputs();

        // Randomized traffic
        dl = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 99) < 3) dl = ~dl;
            bus.downloading  = dl;
            bus.reset_req    = ($urandom_range(0, 49) == 0);
            bus.loader_write = ($urandom_range(0, 3) == 0);
            bus.loader_addr  = ADDR_W'($urandom);
            bus.loader_data  = 8'($urandom);
            bus.nes_addr     = ADDR_W'($urandom);
            bus.nes_dout     = 8'($urandom);
            bus.nes_read_cpu = 1'($urandom);
            bus.nes_read_ppu = 1'($urandom);
            bus.nes_write    = 1'($urandom);
            cycle();
        end
        idle_inputs();
        bus.reset_req = 1'b0;

        // Async reset during phase 1 of an active window, with one entry queued
        bus.downloading = 1'b1;
        repeat (12) cycle();
        to_phase(3);
        strobe(22'h00AAAA, 8'h77);
        strobe(22'h00BBBB, 8'h88);
        check("pre_reset_we", 32'(bus.sd_we), 32'(1));
        reset = 1'b1;
        m_reset();
        #1;
        check("async_sd_we", 32'(bus.sd_we), 32'(0));
        check("async_reset_nes", 32'(bus.reset_nes), 32'(1));
        compare_all();
        cycle();
        bus.downloading = 1'b0;
        reset = 1'b0;
        repeat (8) cycle();
        check("post_reset_busy", 32'(bus.loader_busy), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
